// File: rtl/avr_data_bus.sv
// avr_data_bus: data-space responder behind the core's load/store port.
// Hosts the data SRAM, PORTB/DDRB/PINB and Timer0 with its overflow interrupt.
module avr_data_bus #(
  parameter logic [15:0] RAM_BASE = 16'h0100,
  parameter int          RAM_SIZE = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  input  logic [7:0]  pin_b,
  output logic [7:0]  port_b,
  output logic [7:0]  ddr_b,
  output logic        irq_tov0
);

  localparam int          AW       = $clog2(RAM_SIZE);
  localparam logic [16:0] RAM_END  = 17'(RAM_BASE) + 17'(RAM_SIZE);
  localparam logic [15:0] A_PINB   = 16'h0023;
  localparam logic [15:0] A_DDRB   = 16'h0024;
  localparam logic [15:0] A_PORTB  = 16'h0025;
  localparam logic [15:0] A_TIFR0  = 16'h0035;
  localparam logic [15:0] A_TCCR0B = 16'h0045;
  localparam logic [15:0] A_TCNT0  = 16'h0046;
  localparam logic [15:0] A_TIMSK0 = 16'h006E;

  logic [7:0]    mem [RAM_SIZE];
  logic [7:0]    pin_p0;
  logic [7:0]    pin_p1;
  logic [9:0]    prescaler;
  logic [7:0]    tcnt0;
  logic [2:0]    cs;
  logic          tov0;
  logic          toie0;
  logic          in_ram;
  logic [AW-1:0] ram_idx;
  logic          wr;
  logic          tick;
  logic          tcnt_wr;
  logic          ovf;
  logic [7:0]    rd_next;

  // Upper bound is checked in 17 bits so addresses past the SRAM never alias into it.
  assign in_ram  = ({1'b0, address} >= 17'(RAM_BASE)) && ({1'b0, address} < RAM_END);
  assign ram_idx = AW'(address - RAM_BASE);
  assign wr      = we & ~reset;
  assign tcnt_wr = wr && (address == A_TCNT0);
  assign ovf     = tick && !tcnt_wr && (tcnt0 == 8'hFF);
  assign irq_tov0 = tov0 & toie0;

  always_comb begin
    tick = 1'b0;
    case (cs)
      3'd1:    tick = 1'b1;
      3'd2:    tick = &prescaler[2:0];
      3'd3:    tick = &prescaler[5:0];
      3'd4:    tick = &prescaler[7:0];
      3'd5:    tick = &prescaler;
      default: tick = 1'b0;
    endcase
  end

  always_comb begin
    rd_next = 8'h00;
    case (address)
      A_PINB:   rd_next = pin_p1;
      A_DDRB:   rd_next = ddr_b;
      A_PORTB:  rd_next = port_b;
      A_TIFR0:  rd_next = {7'b0, tov0};
      A_TCCR0B: rd_next = {5'b0, cs};
      A_TCNT0:  rd_next = tcnt0;
      A_TIMSK0: rd_next = {7'b0, toie0};
      default:  rd_next = in_ram ? mem[ram_idx] : 8'h00;
    endcase
  end

  // SRAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clock) begin
    if (wr && in_ram) begin
      mem[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata     <= 8'h00;
      port_b    <= 8'h00;
      ddr_b     <= 8'h00;
      tcnt0     <= 8'h00;
      cs        <= 3'd0;
      tov0      <= 1'b0;
      toie0     <= 1'b0;
      prescaler <= 10'd0;
      pin_p0    <= 8'h00;
      pin_p1    <= 8'h00;
    end else begin
      rdata     <= rd_next;
      pin_p0    <= pin_b;
      pin_p1    <= pin_p0;
      prescaler <= prescaler + 10'd1;

      // A CPU store to TCNT0 takes precedence over a same-cycle tick.
      if (tcnt_wr) begin
        tcnt0 <= wdata;
      end else if (tick) begin
        tcnt0 <= tcnt0 + 8'd1;
      end

      if (ovf) begin
        tov0 <= 1'b1;
      end else if (wr && (address == A_TIFR0) && wdata[0]) begin
        tov0 <= 1'b0;
      end

      if (wr) begin
        case (address)
          A_PINB:   port_b <= port_b ^ wdata;
          A_DDRB:   ddr_b  <= wdata;
          A_PORTB:  port_b <= wdata;
          A_TCCR0B: cs     <= wdata[2:0];
          A_TIMSK0: toie0  <= wdata[0];
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avr_data_bus.sv
// Bench for avr_data_bus: directed scenarios plus randomized traffic checked
// against a behavioural model of the data space.
`timescale 1ns/1ps
module tb_avr_data_bus;

  localparam logic [15:0] RAM_BASE = 16'h0100;
  localparam int          RAM_SIZE = 2048;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic [7:0]  pin_b;
  logic [7:0]  port_b;
  logic [7:0]  ddr_b;
  logic        irq_tov0;

  int n_tests = 0;
  int n_fail  = 0;

  avr_data_bus #(.RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE)) dut (
    .clock(clock), .reset(reset), .address(address), .wdata(wdata), .we(we),
    .rdata(rdata), .pin_b(pin_b), .port_b(port_b), .ddr_b(ddr_b), .irq_tov0(irq_tov0)
  );

  always #5 clock = ~clock;

  // Behavioural model of the data space
  logic [7:0] m_mem [int];
  logic [7:0] m_port, m_ddr, m_tcnt;
  logic [2:0] m_cs;
  logic       m_tov, m_toie;
  int         m_clocks;
  logic [7:0] m_pin_last, m_pin_prev;
  logic [7:0] m_rdata;
  logic       m_rdata_known;

  function automatic logic m_in_ram(input logic [15:0] a);
    return (int'(a) >= int'(RAM_BASE)) && (int'(a) < int'(RAM_BASE) + RAM_SIZE);
  endfunction

  function automatic int m_divisor(input logic [2:0] c);
    int r = 0;
    case (c)
      3'd1: r = 1;
      3'd2: r = 8;
      3'd3: r = 64;
      3'd4: r = 256;
      3'd5: r = 1024;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic m_tick_next();
    int d = m_divisor(m_cs);
    return (d != 0) && ((m_clocks % d) == d - 1);
  endfunction

  task automatic cycle(input logic r, input logic [15:0] a, input logic [7:0] d, input logic w);
    logic [7:0] exp_rd;
    logic       known;
    logic       tk;
    logic       ovf;
    int         idx;
    reset = r; address = a; wdata = d; we = w;
    known  = 1'b1;
    exp_rd = 8'h00;
    idx    = int'(a) - int'(RAM_BASE);
    case (a)
      16'h0023: exp_rd = m_pin_prev;
      16'h0024: exp_rd = m_ddr;
      16'h0025: exp_rd = m_port;
      16'h0035: exp_rd = {7'b0, m_tov};
      16'h0045: exp_rd = {5'b0, m_cs};
      16'h0046: exp_rd = m_tcnt;
      16'h006E: exp_rd = {7'b0, m_toie};
      default: begin
        if (m_in_ram(a)) begin
          if (m_mem.exists(idx)) exp_rd = m_mem[idx];
          else known = 1'b0;
        end
      end
    endcase
    tk = m_tick_next();
    @(posedge clock);
    if (r) begin
      m_port = 8'h00; m_ddr = 8'h00; m_tcnt = 8'h00; m_cs = 3'd0;
      m_tov = 1'b0; m_toie = 1'b0; m_clocks = 0;
      m_pin_last = 8'h00; m_pin_prev = 8'h00;
      exp_rd = 8'h00; known = 1'b1;
    end else begin
      m_pin_prev = m_pin_last;
      m_pin_last = pin_b;
      m_clocks = (m_clocks + 1) % 1024;
      ovf = tk && !(w && a == 16'h0046) && (m_tcnt == 8'hFF);
      if (w && a == 16'h0046) m_tcnt = d;
      else if (tk) m_tcnt = m_tcnt + 8'd1;
      if (ovf) m_tov = 1'b1;
      else if (w && a == 16'h0035 && d[0]) m_tov = 1'b0;
      if (w) begin
        case (a)
          16'h0023: m_port = m_port ^ d;
          16'h0024: m_ddr  = d;
          16'h0025: m_port = d;
          16'h0045: m_cs   = d[2:0];
          16'h006E: m_toie = d[0];
          default:  if (m_in_ram(a)) m_mem[idx] = d;
        endcase
      end
    end
    m_rdata = exp_rd;
    m_rdata_known = known;
    #1;
  endtask

  task automatic test_reset();
    pin_b = 8'h00;
    cycle(1'b1, 16'h0000, 8'h00, 1'b0);
    cycle(1'b1, 16'h0000, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    n_tests++; if (port_b !== 8'h00) begin n_fail++; $display("FAIL reset_port_b: got %h want 00", port_b); end
    n_tests++; if (ddr_b !== 8'h00) begin n_fail++; $display("FAIL reset_ddr_b: got %h want 00", ddr_b); end
    n_tests++; if (irq_tov0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_tov0); end
    cycle(1'b0, 16'h0100, 8'hA5, 1'b1);
    cycle(1'b0, 16'h0100, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL sram_rd_0100: got %h want a5", rdata); end
    cycle(1'b0, 16'h0100, 8'h77, 1'b1);
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL read_first: got %h want a5", rdata); end
    cycle(1'b0, 16'h0100, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h77) begin n_fail++; $display("FAIL sram_rewrite: got %h want 77", rdata); end
    cycle(1'b0, 16'h0100, 8'hA5, 1'b1);
  endtask

  task automatic test_ram_bounds();
    cycle(1'b0, 16'h08FF, 8'h3C, 1'b1);
    cycle(1'b0, 16'h0900, 8'h3C, 1'b1);
    cycle(1'b0, 16'h001F, 8'h3C, 1'b1);
    cycle(1'b0, 16'h00FF, 8'h3C, 1'b1);
    cycle(1'b0, 16'h08FF, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL ram_top: got %h want 3c", rdata); end
    cycle(1'b0, 16'h0900, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL ram_past_end: got %h want 00", rdata); end
    cycle(1'b0, 16'h001F, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL core_reg: got %h want 00", rdata); end
    cycle(1'b0, 16'h00FF, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL below_base: got %h want 00", rdata); end
    cycle(1'b0, 16'h0100, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL no_wrap: got %h want a5", rdata); end
  endtask

  task automatic test_portb();
    cycle(1'b0, 16'h0025, 8'h0F, 1'b1);
    n_tests++; if (port_b !== 8'h0F) begin n_fail++; $display("FAIL portb_write: got %h want 0f", port_b); end
    cycle(1'b0, 16'h0023, 8'hFF, 1'b1);
    n_tests++; if (port_b !== 8'hF0) begin n_fail++; $display("FAIL pinb_toggle: got %h want f0", port_b); end
    cycle(1'b0, 16'h0024, 8'hA6, 1'b1);
    n_tests++; if (ddr_b !== 8'hA6) begin n_fail++; $display("FAIL ddrb_write: got %h want a6", ddr_b); end
    cycle(1'b0, 16'h0024, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'hA6) begin n_fail++; $display("FAIL ddrb_read: got %h want a6", rdata); end
    cycle(1'b0, 16'h0025, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'hF0) begin n_fail++; $display("FAIL portb_read: got %h want f0", rdata); end
    pin_b = 8'h55;
    cycle(1'b0, 16'h0000, 8'h00, 1'b0);
    cycle(1'b0, 16'h0023, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL pinb_early: got %h want 00", rdata); end
    cycle(1'b0, 16'h0023, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h55) begin n_fail++; $display("FAIL pinb_sync: got %h want 55", rdata); end
  endtask

  task automatic test_timer_ovf();
    cycle(1'b0, 16'h0045, 8'hF9, 1'b1);
    cycle(1'b0, 16'h0045, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL tccr0b_mask: got %h want 01", rdata); end
    cycle(1'b0, 16'h0046, 8'hFE, 1'b1);
    cycle(1'b0, 16'h006E, 8'h01, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b0) begin n_fail++; $display("FAIL irq_before_ovf: got %b want 0", irq_tov0); end
    cycle(1'b0, 16'h0000, 8'h00, 1'b0);
    n_tests++; if (irq_tov0 !== 1'b1) begin n_fail++; $display("FAIL irq_ovf: got %b want 1", irq_tov0); end
    cycle(1'b0, 16'h0046, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL tcnt_wrapped: got %h want 00", rdata); end
    cycle(1'b0, 16'h0035, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL tifr_read: got %h want 01", rdata); end
    cycle(1'b0, 16'h0035, 8'h00, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b1) begin n_fail++; $display("FAIL tifr_write0: got %b want 1", irq_tov0); end
    cycle(1'b0, 16'h0035, 8'h01, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b0) begin n_fail++; $display("FAIL tifr_clear: got %b want 0", irq_tov0); end
    cycle(1'b0, 16'h0046, 8'hFF, 1'b1);
    cycle(1'b0, 16'h0035, 8'h01, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b want 1", irq_tov0); end
    cycle(1'b0, 16'h0035, 8'h01, 1'b1);
    cycle(1'b0, 16'h0046, 8'hFF, 1'b1);
    cycle(1'b0, 16'h0046, 8'hFF, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b0) begin n_fail++; $display("FAIL write_beats_tick_irq: got %b want 0", irq_tov0); end
    cycle(1'b0, 16'h0046, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'hFF) begin n_fail++; $display("FAIL write_beats_tick_val: got %h want ff", rdata); end
    cycle(1'b0, 16'h006E, 8'h00, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b0) begin n_fail++; $display("FAIL toie_gate: got %b want 0", irq_tov0); end
    cycle(1'b0, 16'h0035, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL tov_held: got %h want 01", rdata); end
    cycle(1'b0, 16'h0035, 8'h01, 1'b1);
  endtask

  task automatic test_prescale();
    logic [7:0] prev;
    int last_change;
    int n_changes;
    int guard;
    cycle(1'b0, 16'h0045, 8'h03, 1'b1);
    cycle(1'b0, 16'h0046, 8'h00, 1'b0);
    prev = rdata;
    last_change = -1;
    n_changes = 0;
    for (int i = 1; i < 200; i++) begin
      cycle(1'b0, 16'h0046, 8'h00, 1'b0);
      n_tests++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL cs3_tcnt[%0d]: got %h want %h", i, rdata, m_rdata); end
      if (rdata != prev) begin
        if (last_change >= 0) begin
          n_tests++;
          if (i - last_change != 64) begin n_fail++; $display("FAIL cs3_period: got %0d want 64", i - last_change); end
        end
        last_change = i;
        n_changes++;
        prev = rdata;
      end
    end
    n_tests++; if (n_changes < 2) begin n_fail++; $display("FAIL cs3_advance: got %0d ticks want >=2", n_changes); end
    guard = 0;
    while (!m_tick_next() && guard < 70) begin
      cycle(1'b0, 16'h0000, 8'h00, 1'b0);
      guard++;
    end
    n_tests++; if (guard >= 70) begin n_fail++; $display("FAIL cs3_tick_search: got %0d cycles want <70", guard); end
    cycle(1'b0, 16'h0046, 8'h10, 1'b1);
    cycle(1'b0, 16'h0046, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h10) begin n_fail++; $display("FAIL tcnt_write_on_tick: got %h want 10", rdata); end
    cycle(1'b0, 16'h0046, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h10) begin n_fail++; $display("FAIL tcnt_hold: got %h want 10", rdata); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] regs [7];
    regs = '{16'h0023, 16'h0046, 16'h0045, 16'h0035, 16'h006E, 16'h0025, 16'h0024};
    cycle(1'b0, 16'h0045, 8'h01, 1'b1);
    cycle(1'b0, 16'h006E, 8'h01, 1'b1);
    cycle(1'b0, 16'h0046, 8'hFF, 1'b1);
    cycle(1'b0, 16'h0025, 8'h5A, 1'b1);
    cycle(1'b0, 16'h0024, 8'hC3, 1'b1);
    n_tests++; if (irq_tov0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq_tov0); end
    cycle(1'b1, 16'h0100, 8'h00, 1'b1);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_rdata: got %h want 00", rdata); end
    n_tests++; if (port_b !== 8'h00) begin n_fail++; $display("FAIL mid_reset_port_b: got %h want 00", port_b); end
    n_tests++; if (ddr_b !== 8'h00) begin n_fail++; $display("FAIL mid_reset_ddr_b: got %h want 00", ddr_b); end
    n_tests++; if (irq_tov0 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b want 0", irq_tov0); end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, regs[i], 8'h00, 1'b0);
      n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL post_reset_reg_%h: got %h want 00", regs[i], rdata); end
    end
    cycle(1'b0, 16'h0046, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL timer_stopped: got %h want 00", rdata); end
    cycle(1'b0, 16'h0100, 8'h00, 1'b0);
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL sram_kept: got %h want a5", rdata); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic        r;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: a = 16'($urandom_range(0, 31));
        1: a = 16'h0023;
        2: a = 16'h0024;
        3: a = 16'h0025;
        4: a = 16'h0035;
        5: a = 16'h0045;
        6: a = 16'h0046;
        7: a = 16'h006E;
        8: a = RAM_BASE + 16'($urandom_range(0, 15));
        default: a = 16'($urandom);
      endcase
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) pin_b = 8'($urandom);
      cycle(r, a, d, w);
      if (m_rdata_known) begin
        n_tests++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d] a=%h: got %h want %h", i, a, rdata, m_rdata); end
      end
      n_tests++; if (port_b !== m_port) begin n_fail++; $display("FAIL rand_port_b[%0d]: got %h want %h", i, port_b, m_port); end
      n_tests++; if (ddr_b !== m_ddr) begin n_fail++; $display("FAIL rand_ddr_b[%0d]: got %h want %h", i, ddr_b, m_ddr); end
      n_tests++; if (irq_tov0 !== (m_tov & m_toie)) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq_tov0, m_tov & m_toie); end
    end
  endtask

  initial begin
    reset = 1'b1; address = 16'h0000; wdata = 8'h00; we = 1'b0; pin_b = 8'h00;
    test_reset();
    test_ram_bounds();
    test_portb();
    test_timer_ovf();
    test_prescale();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
